grid_walk_checker: RTL

Parametrised, cycle-accurate checker for grid-walk puzzles. A host streams a 4-byte header (start and goal coordinates), then HEIGHT×WIDTH per-cell visit budgets, then a stream of move codes. The block tracks the player, consumes one budget unit per cell entered, and reports win or loss. It supersedes the fixed 10×10 puzzle checker, adding:

- configurable grid size and cell width
- optional diagonal moves
- optional toroidal wrap
- header validation
- an O(1) all-cells-exhausted check via a running budget sum
- sticky, observable status

---
 rtl/grid_walk_checker.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/grid_walk_checker.sv
// rtl/grid_walk_checker.sv - grid-walk puzzle checker with per-cell budgets, optional diagonals and wrap
module grid_walk_checker #(
    parameter int HEIGHT     = 10,
    parameter int WIDTH      = 10,
    parameter int CELL_W     = 8,
    parameter int ALLOW_DIAG = 0,
    parameter int WRAP       = 0,
    localparam int SUM_W     = CELL_W + $clog2(HEIGHT * WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic             clear,
    output logic             in_ready,
    output logic             result,
    output logic             lost,
    output logic [2:0]       phase,
    output logic [7:0]       pos_x,
    output logic [7:0]       pos_y,
    output logic [SUM_W-1:0] remaining,
    output logic [15:0]      move_cnt
);

    localparam int CELLS = HEIGHT * WIDTH;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(CELLS - 1);
    localparam logic [8:0] W9 = 9'(WIDTH);
    localparam logic [8:0] H9 = 9'(HEIGHT);
    localparam logic signed [9:0] W_S = 10'(WIDTH);
    localparam logic signed [9:0] H_S = 10'(HEIGHT);

    localparam logic [2:0] LOAD_HDR  = 3'd0;
    localparam logic [2:0] LOAD_GRID = 3'd1;
    localparam logic [2:0] PLAY      = 3'd2;
    localparam logic [2:0] WON       = 3'd3;
    localparam logic [2:0] LOST      = 3'd4;

    logic [2:0]        state;
    logic [1:0]        hdr_idx;
    logic [AW-1:0]     grid_idx;
    logic [7:0]        goal_x;
    logic [7:0]        goal_y;
    logic [CELL_W-1:0] cells [DEPTH];

    logic signed [9:0] dx;
    logic signed [9:0] dy;
    logic              code_ok;
    logic signed [9:0] tx_s;
    logic signed [9:0] ty_s;
    logic              x_lo, x_hi, y_lo, y_hi;
    logic              off_grid;
    logic [7:0]        tx;
    logic [7:0]        ty;
    logic [AW-1:0]     tgt_idx;
    logic [CELL_W-1:0] tgt_budget;
    logic              at_goal;
    logic              hdr_bad;

    assign phase    = state;
    assign in_ready = (state == LOAD_HDR) || (state == LOAD_GRID) || (state == PLAY);
    assign result   = (state == WON);
    assign lost     = (state == LOST);

    // Translate a move code into a unit step; diagonals only count when enabled.
    always_comb begin
        dx      = 10'sd0;
        dy      = 10'sd0;
        code_ok = 1'b1;
        case (data_in)
            8'd78: dy = -10'sd1;
            8'd83: dy = 10'sd1;
            8'd69: dx = 10'sd1;
            8'd87: dx = -10'sd1;
            8'd49: begin dx = 10'sd1;  dy = -10'sd1; code_ok = (ALLOW_DIAG != 0); end
            8'd50: begin dx = -10'sd1; dy = -10'sd1; code_ok = (ALLOW_DIAG != 0); end
            8'd51: begin dx = 10'sd1;  dy = 10'sd1;  code_ok = (ALLOW_DIAG != 0); end
            8'd52: begin dx = -10'sd1; dy = 10'sd1;  code_ok = (ALLOW_DIAG != 0); end
            default: code_ok = 1'b0;
        endcase
    end

    assign tx_s = $signed({2'b00, pos_x}) + dx;
    assign ty_s = $signed({2'b00, pos_y}) + dy;
    assign x_lo = (tx_s < 10'sd0);
    assign x_hi = (tx_s >= W_S);
    assign y_lo = (ty_s < 10'sd0);
    assign y_hi = (ty_s >= H_S);
    assign off_grid = (WRAP == 0) && (x_lo || x_hi || y_lo || y_hi);

    // Per-axis target coordinate; the wrapped value is only used when wrap is enabled.
    always_comb begin
        if (x_lo)      tx = 8'(WIDTH - 1);
        else if (x_hi) tx = 8'd0;
        else           tx = tx_s[7:0];
        if (y_lo)      ty = 8'(HEIGHT - 1);
        else if (y_hi) ty = 8'd0;
        else           ty = ty_s[7:0];
    end

    assign tgt_idx    = AW'(32'(ty) * 32'(WIDTH) + 32'(tx));
    assign tgt_budget = cells[tgt_idx];
    assign at_goal    = (tx == goal_x) && (ty == goal_y);
    assign hdr_bad    = ({1'b0, pos_x} >= W9) || ({1'b0, pos_y} >= H9) ||
                        ({1'b0, goal_x} >= W9) || ({1'b0, data_in} >= H9);

    // Main sequencer: header capture, grid load with running sum, then move evaluation.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state     <= LOAD_HDR;
            hdr_idx   <= 2'd0;
            grid_idx  <= '0;
            pos_x     <= 8'd0;
            pos_y     <= 8'd0;
            goal_x    <= 8'd0;
            goal_y    <= 8'd0;
            remaining <= '0;
            move_cnt  <= 16'd0;
            for (int i = 0; i < DEPTH; i++) cells[i] <= '0;
        end else if (data_valid && in_ready) begin
            case (state)
                LOAD_HDR: begin
                    hdr_idx <= hdr_idx + 2'd1;
                    case (hdr_idx)
                        2'd0: pos_x  <= data_in;
                        2'd1: pos_y  <= data_in;
                        2'd2: goal_x <= data_in;
                        default: begin
                            goal_y <= data_in;
                            state  <= hdr_bad ? LOST : LOAD_GRID;
                        end
                    endcase
                end
                LOAD_GRID: begin
                    cells[grid_idx] <= data_in[CELL_W-1:0];
                    remaining       <= remaining + SUM_W'(data_in[CELL_W-1:0]);
                    if (grid_idx == LAST_IDX) state <= PLAY;
                    else                      grid_idx <= grid_idx + AW'(1);
                end
                PLAY: begin
                    if (move_cnt != 16'hFFFF) move_cnt <= move_cnt + 16'd1;
                    if (!code_ok || off_grid || (tgt_budget == '0)) begin
                        state <= LOST;
                    end else begin
                        pos_x            <= tx;
                        pos_y            <= ty;
                        cells[tgt_idx]   <= tgt_budget - CELL_W'(1);
                        remaining        <= remaining - SUM_W'(1);
                        if (at_goal && (remaining == SUM_W'(1))) state <= WON;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
